// File: rtl/vga_pkg.sv
// Shared 640x480@60 raster constants and the sync/blank control word type.
// Imported by vga_timing_gen and vga_delay_line.
package vga_pkg;

  localparam int VGA_H_ACTIVE = 640;
  localparam int VGA_H_FP     = 16;
  localparam int VGA_H_SYNC   = 96;
  localparam int VGA_H_BP     = 48;
  localparam int VGA_H_TOTAL  = VGA_H_ACTIVE + VGA_H_FP + VGA_H_SYNC + VGA_H_BP;

  localparam int VGA_V_ACTIVE = 480;
  localparam int VGA_V_FP     = 10;
  localparam int VGA_V_SYNC   = 2;
  localparam int VGA_V_BP     = 33;
  localparam int VGA_V_TOTAL  = VGA_V_ACTIVE + VGA_V_FP + VGA_V_SYNC + VGA_V_BP;

  // Syncs are active low, so the idle word has both syncs high and video off.
  typedef struct packed {
    logic hs;
    logic vs;
    logic von;
  } vga_ctl_t;

  localparam vga_ctl_t VGA_CTL_IDLE = '{hs: 1'b1, vs: 1'b1, von: 1'b0};

endpackage

// File: rtl/vga_delay_line.sv
// Reset-to-idle shift register used to align sync/blank with the registered RGB path.
// DEPTH 0 degenerates to a plain wire.
module vga_delay_line #(
  parameter int  DEPTH = 2,
  parameter type T     = logic,
  parameter T    IDLE  = T'(0)
) (
  input  logic clk,
  input  logic rst_n,
  input  T     d,
  output T     q
);

  generate
    if (DEPTH == 0) begin : g_wire
      assign q = d;
    end else begin : g_pipe
      T pipe_q [DEPTH];

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int i = 0; i < DEPTH; i++) pipe_q[i] <= IDLE;
        end else begin
          pipe_q[0] <= d;
          for (int i = 1; i < DEPTH; i++) pipe_q[i] <= pipe_q[i-1];
        end
      end

      assign q = pipe_q[DEPTH-1];
    end
  endgenerate

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: counters, undelayed active-video decode, PIPE_DLY-aligned syncs/blank.
// Optional completed-frame counter enabled by defining VGA_FRAME_CNT_EN.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int H_ACTIVE = VGA_H_ACTIVE,
  parameter int H_FP     = VGA_H_FP,
  parameter int H_SYNC   = VGA_H_SYNC,
  parameter int H_BP     = VGA_H_BP,
  parameter int V_ACTIVE = VGA_V_ACTIVE,
  parameter int V_FP     = VGA_V_FP,
  parameter int V_SYNC   = VGA_V_SYNC,
  parameter int V_BP     = VGA_V_BP,
  parameter int PIPE_DLY = 2            // legal 0..4
) (
  input  logic        pll_clk,
  input  logic        reset_n,
  input  logic        pll_locked,
  output logic [11:0] horz_count,
  output logic [11:0] vert_count,
  output logic        v_on,
  output logic [9:0]  pix_x,
  output logic [9:0]  pix_y,
  output logic        line_start,
  output logic        frame_start,
  output logic        horz_sync,
  output logic        vert_sync,
  output logic        blank_n,
  output logic [15:0] frame_cnt
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [11:0] H_LAST = 12'(H_TOTAL - 1);
  localparam logic [11:0] V_LAST = 12'(V_TOTAL - 1);
  localparam logic [11:0] H_ACT  = 12'(H_ACTIVE);
  localparam logic [11:0] V_ACT  = 12'(V_ACTIVE);
  localparam logic [11:0] H_SS   = 12'(H_ACTIVE + H_FP);
  localparam logic [11:0] H_SE   = 12'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [11:0] V_SS   = 12'(V_ACTIVE + V_FP);
  localparam logic [11:0] V_SE   = 12'(V_ACTIVE + V_FP + V_SYNC);

  logic [11:0] h_q;
  logic [11:0] v_q;
  logic        h_wrap;
  logic        v_wrap;
  logic        run;
  vga_ctl_t    ctl0;
  vga_ctl_t    ctl_pin;

  assign run    = reset_n && pll_locked;
  assign h_wrap = (h_q == H_LAST);
  assign v_wrap = (v_q == V_LAST);

  // Losing lock parks the raster at the origin; there is no attempt to resume mid-line.
  always_ff @(posedge pll_clk or negedge reset_n) begin
    if (!reset_n) begin
      h_q <= '0;
      v_q <= '0;
    end else if (!pll_locked) begin
      h_q <= '0;
      v_q <= '0;
    end else if (h_wrap) begin
      h_q <= '0;
      v_q <= v_wrap ? '0 : v_q + 12'd1;
    end else begin
      h_q <= h_q + 12'd1;
    end
  end

  always_comb begin
    ctl0 = VGA_CTL_IDLE;
    if (run) begin
      ctl0.von = (h_q < H_ACT) && (v_q < V_ACT);
      ctl0.hs  = !((h_q >= H_SS) && (h_q < H_SE));
      ctl0.vs  = !((v_q >= V_SS) && (v_q < V_SE));
    end
  end

  assign horz_count  = h_q;
  assign vert_count  = v_q;
  assign v_on        = ctl0.von;
  assign pix_x       = ctl0.von ? h_q[9:0] : '0;
  assign pix_y       = ctl0.von ? v_q[9:0] : '0;
  assign line_start  = run && (h_q == '0);
  assign frame_start = line_start && (v_q == '0);

  // Delay matches the downstream colour stage so syncs and RGB reach the pins together.
  vga_delay_line #(
    .DEPTH (PIPE_DLY),
    .T     (vga_ctl_t),
    .IDLE  (VGA_CTL_IDLE)
  ) u_dly (
    .clk   (pll_clk),
    .rst_n (reset_n),
    .d     (ctl0),
    .q     (ctl_pin)
  );

  assign horz_sync = ctl_pin.hs;
  assign vert_sync = ctl_pin.vs;
  assign blank_n   = ctl_pin.von;

`ifdef VGA_FRAME_CNT_EN
  logic [15:0] frame_q;

  always_ff @(posedge pll_clk or negedge reset_n) begin
    if (!reset_n) begin
      frame_q <= '0;
    end else if (pll_locked && h_wrap && v_wrap) begin
      frame_q <= frame_q + 16'd1;
    end
  end

  assign frame_cnt = frame_q;
`else
  assign frame_cnt = 16'h0;
`endif

endmodule
